// File: rtl/rom_rd_ctrl_pkg.sv
// rtl/rom_rd_ctrl_pkg.sv - shared types and constants for the ROM burst read controller
package rom_rd_ctrl_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int LEN_W      = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic        last;
    logic        err;
    logic [63:0] data;
  } rom_rd_beat_t;

endpackage

// File: rtl/rom_rd_fifo2.sv
// rtl/rom_rd_fifo2.sv - two-entry response beat FIFO, push and pop allowed together even when full
module rom_rd_fifo2
  import rom_rd_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  rom_rd_beat_t din,
  input  logic         pop,
  output rom_rd_beat_t head,
  output logic [1:0]   count
);

  rom_rd_beat_t mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  // When full, wr_ptr equals rd_ptr: a push alongside a pop overwrites the departing head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rom_rd_ctrl.sv
// rtl/rom_rd_ctrl.sv - burst read controller in front of a one-cycle-latency 64-bit ROM
module rom_rd_ctrl
  import rom_rd_ctrl_pkg::*;
#(
  parameter int abits = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [abits+2:0] i_req_addr,
  input  logic [LEN_W-1:0] i_req_len,
  output logic [abits-1:0] o_rom_addr,
  input  logic [63:0]      i_rom_data,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [63:0]      o_resp_data,
  output logic             o_resp_last,
  output logic             o_resp_err
);

  state_t           state;
  state_t           state_nx;
  logic [abits-1:0] r_addr;
  logic [abits-1:0] rom_addr_q;
  logic [LEN_W-1:0] r_left;
  logic             r_err;
  logic             inflight;
  logic             infl_last;
  logic             infl_err;
  logic             issue;
  logic             credit;
  logic             pop;
  logic [1:0]       fifo_count;
  rom_rd_beat_t     beat_in;
  rom_rd_beat_t     head;

  assign pop = o_resp_valid && i_resp_ready;

  // FIFO slots plus the read in flight may never exceed the FIFO depth.
  assign credit = (({1'b0, fifo_count} + {2'b00, inflight}) < 3'(FIFO_DEPTH)) || pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    o_req_ready = 1'b0;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_nx = BURST;
        end
      end
      BURST: begin
        issue = credit;
        if (issue && (r_left == '0)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_left     <= '0;
      r_err      <= 1'b0;
      rom_addr_q <= '0;
      inflight   <= 1'b0;
      infl_last  <= 1'b0;
      infl_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && i_req_valid) begin
        r_addr <= i_req_addr[abits+2:3];
        r_left <= i_req_len;
        r_err  <= |i_req_addr[2:0];
      end else if (issue && (r_left != '0)) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 1'b1;
      end
      rom_addr_q <= o_rom_addr;
      inflight   <= issue;
      infl_last  <= issue && (r_left == '0);
      infl_err   <= r_err;
    end
  end

  // The address is presented combinationally in the issue cycle and held otherwise.
  assign o_rom_addr = issue ? r_addr : rom_addr_q;

  assign beat_in = '{last: infl_last, err: infl_err, data: i_rom_data};

  rom_rd_fifo2 u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (inflight),
    .din   (beat_in),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  assign o_resp_valid = (fifo_count != 2'd0);
  assign o_resp_data  = head.data;
  assign o_resp_last  = head.last;
  assign o_resp_err   = head.err;

endmodule

// File: tb/tb_rom_rd_ctrl.sv
// tb/tb_rom_rd_ctrl.sv - scoreboard bench for rom_rd_ctrl with a behavioural ROM and burst model
`timescale 1ns/1ps
module tb_rom_rd_ctrl;

  localparam int AB = 12;

  typedef struct {
    logic [AB-1:0] word;
    logic          last;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AB+2:0] req_addr = '0;
  logic [2:0]    req_len = '0;
  logic [AB-1:0] rom_addr;
  logic [63:0]   rom_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [63:0]   resp_data;
  logic          resp_last;
  logic          resp_err;

  int   vecs = 0;
  int   errs = 0;
  int   beats_popped = 0;
  bit   rnd_ready = 1'b0;
  time  hs_time = 0;
  exp_t sb[$];

  rom_rd_ctrl #(.abits(AB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_len    (req_len),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_data  (resp_data),
    .o_resp_last  (resp_last),
    .o_resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_val(input logic [AB-1:0] w);
    logic [31:0] i32;
    i32 = 32'(w);
    return {~i32, i32};
  endfunction

  // Synchronous ROM: word[i] = {~i, i}, one cycle of read latency.
  always @(posedge clk) rom_data <= word_val(rom_addr);

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted beat must be the next one the model predicted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_beat", {resp_last, resp_err, resp_data}, 66'd0);
          chk("spurious_beat_flag", 66'd1, 66'd0);
        end else begin
          e = sb.pop_front();
          chk("beat", {resp_last, resp_err, resp_data}, {e.last, e.err, word_val(e.word)});
        end
        beats_popped++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_req(input logic [AB+2:0] addr, input logic [2:0] len);
    int   n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        chk("req_accept_timeout", 66'd0, 66'd1);
        break;
      end
    end
    @(posedge clk);
    hs_time = $time;
    for (int k = 0; k <= int'(len); k++) begin
      e.word = addr[AB+2:3] + AB'(k);
      e.last = (k == int'(len));
      e.err  = |addr[2:0];
      sb.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) break;
      n++;
      if (n > 400) break;
    end
    chk(name, 66'(sb.size()), 66'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    int  start;
    time tv;

    #2;
    chk("rst_resp_valid", 66'(resp_valid), 66'd0);
    chk("rst_resp_word", {resp_last, resp_err, resp_data}, 66'd0);
    chk("rst_rom_addr", 66'(rom_addr), 66'd0);
    chk("rst_req_ready", 66'(req_ready), 66'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single burst, ready high: latency and back-to-back beats.
    resp_ready = 1'b1;
    do_req(15'h040, 3'd3);
    n = 0;
    tv = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        tv = $time;
        break;
      end
      n++;
      if (n > 20) break;
    end
    chk("first_beat_latency", 66'(tv - hs_time), 66'd25);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("no_bubble", 66'(resp_valid), 66'd1);
    end
    wait_drain("drain_t1");

    // Word address wraps from the top of the ROM to zero.
    do_req(15'h7FF0, 3'd3);
    wait_drain("drain_wrap");

    // Backpressure for 10 cycles from the first valid beat.
    resp_ready = 1'b0;
    do_req(15'h1000, 3'd7);
    n = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
      if (n > 20) break;
    end
    chk("stall_rom_addr_first", 66'(rom_addr), 66'd513);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", 66'(resp_valid), 66'd1);
      chk("stall_word", {resp_last, resp_err, resp_data}, {2'b00, word_val(12'd512)});
      chk("stall_rom_addr", 66'(rom_addr), 66'd513);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_drain("drain_stall");

    // Misaligned single beat.
    do_req(15'h013, 3'd0);
    wait_drain("drain_misaligned");

    // Back-to-back bursts under random backpressure.
    rnd_ready = 1'b1;
    do_req(15'h000, 3'd1);
    do_req(15'h100, 3'd1);
    wait_drain("drain_b2b");

    // Random bursts, random addresses (including misaligned and wrapping).
    for (int r = 0; r < 20; r++) begin
      do_req(15'($urandom_range(0, 32767)), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain("drain_random");
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 resp_ready = 1'b1;

    // Reset after two beats of an 8-beat burst.
    start = beats_popped;
    do_req(15'h0800, 3'd7);
    n = 0;
    forever begin
      @(posedge clk);
      if (beats_popped >= start + 2) break;
      n++;
      if (n > 30) begin
        chk("reset_wait_timeout", 66'd0, 66'd1);
        break;
      end
    end
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_resp_valid", 66'(resp_valid), 66'd0);
    chk("midrst_rom_addr", 66'(rom_addr), 66'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 66'(req_ready), 66'd1);
    chk("post_rst_resp_valid", 66'(resp_valid), 66'd0);
    @(posedge clk);
    #1;
    do_req(15'h0208, 3'd2);
    wait_drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rom_rd_ctrl.md
Name: rom_rd_ctrl

Overview:
Burst read controller placed directly upstream of the 64-bit dual-half inferred ROM (rom_inferred_2x32). It accepts byte-addressed burst read requests on a valid/ready interface and drives the ROM word address. It absorbs the ROM's one-cycle read latency and returns 64-bit beats on a valid/ready response channel with a 2-entry buffer, so response backpressure never loses ROM data. Typical users are the boot ROM bus slave and the instruction prefetch path.

Parameters:
abits, 12, ROM word-address width; must equal the abits of the attached ROM.

Ports:
i_clk  in  1  clock, shared with the ROM.
i_rst  in  1  asynchronous active-high reset.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request accepted when high together with i_req_valid.
i_req_addr  in  abits+3  byte address; bits [abits+2:3] select the word.
i_req_len  in  3  burst length minus 1 (1..8 beats).
o_rom_addr  out  abits  word address presented to the ROM.
i_rom_data  in  64  ROM read data, valid one cycle after the address is issued.
o_resp_valid  out  1  response beat valid.
i_resp_ready  in  1  response beat consumed.
o_resp_data  out  64  response word.
o_resp_last  out  1  final beat of the burst.
o_resp_err  out  1  request was misaligned (i_req_addr[2:0] != 0).

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, o_req_ready=1 after release.
  - o_rom_addr=0, FIFO empty, inflight flag=0, o_resp_valid=0, o_resp_data=0, o_resp_last=0, o_resp_err=0.
  - Reset mid-burst drops all pending and in-flight beats. No partial response follows.
- States:
  - IDLE: o_req_ready=1. On handshake, r_addr<=i_req_addr[abits+2:3], r_left<=i_req_len, r_err<=|i_req_addr[2:0], go to BURST.
  - BURST: o_req_ready=0. Each cycle with issue=1, one read is issued at o_rom_addr=r_addr.
    - If r_left==0, that read is tagged last and state returns to IDLE.
    - Otherwise r_addr<=r_addr+1 (mod 2^abits, wraps from top to 0) and r_left<=r_left-1.
- Issue rule: issue = (state==BURST) && ((fifo_count + inflight) < 2 || (o_resp_valid && i_resp_ready)). This gives a credit-based guarantee that the FIFO never overflows.
- In-flight handling:
  - inflight<=issue each cycle; tags {last, err} are pipelined alongside it.
  - When inflight=1, {last, err, i_rom_data} is pushed into the FIFO that cycle.
- Output:
  - o_resp_* is driven from the FIFO head; pop on o_resp_valid && i_resp_ready.
  - Push and pop in the same cycle are allowed, including push into a full FIFO while it pops.
- Latency: request handshake in cycle 0, ROM address in cycle 1, ROM data in cycle 2, o_resp_valid in cycle 3.
- Throughput: with i_resp_ready held high, 1 beat per cycle and no bubbles within a burst.
- Back-to-back bursts: the next request is accepted in the cycle after the last issue. The issue of the new request does not wait for earlier beats to drain; ordering is preserved by the FIFO.
- Backpressure:
  - i_resp_ready=0 stalls issue once fifo_count+inflight==2.
  - o_resp_data/last/err stay stable while o_resp_valid=1 and i_resp_ready=0.
- o_rom_addr holds its last value when not issuing. The ROM read is side-effect free.
- Misaligned address: the word is still read (low 3 bits ignored), and o_resp_err=1 on every beat of that burst.

Decomposition:
- Package rom_rd_ctrl_pkg:
  - state enum {IDLE, BURST}.
  - struct rom_rd_beat_t {last, err, data[63:0]}.
  - localparam FIFO_DEPTH=2.
  - localparam LEN_W=3.
- Sub-module rom_rd_fifo2: 2-entry FIFO of rom_rd_beat_t with push/pop/count, asynchronous active-high reset, and simultaneous push and pop when full.

Test Plan:
- ROM model word[i] = {~i[31:0], i[31:0]}. Request addr=0x040, len=3 with ready held high -> beats for words 8,9,10,11 in consecutive cycles starting 3 cycles after the handshake; last only on word 11; err=0.
- Request addr=(2^abits-2)*8, len=3 -> words 4094,4095,0,1 (abits=12); last on the 4th beat.
- Request len=7, with i_resp_ready=0 for 10 cycles after the first o_resp_valid, then 1 -> o_resp_valid held with word unchanged; no lost or duplicated beats; 8 beats in order; the issue stall is observed via o_rom_addr holding.
- Request addr=0x013, len=0 -> one beat of word 2, err=1, last=1.
- Two back-to-back requests (0x000 len=1, then 0x100 len=1) with random i_resp_ready -> order is words 0,1,32,33; last on words 1 and 33.
- Assert i_rst for 1 cycle mid-burst, after 2 beats of a len=7 burst -> o_resp_valid=0 immediately; o_req_ready=1 after release; a new request returns only its own data.
